// File: rtl/boot_cfg_pkg.sv
// Shared types for the boot/configuration sequencer.
// Holds the FSM state enum, the boot-address constant and a counter-width helper.
package boot_cfg_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        SELECT,
        REQ,
        WAIT_RESP,
        DONE,
        ERROR
    } state_e;

    localparam logic [31:0] BOOT_ADDR_REG = 32'h1A10_7008;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/boot_cfg_sequencer_if.sv
// Request/grant/response write bus between the sequencer and the interconnect.
// master: req/we/addr/wdata/be out, gnt/rvalid/err in; slave is the mirror.
interface boot_cfg_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_o;
    logic                  we_o;
    logic [ADDR_W-1:0]     addr_o;
    logic [DATA_W-1:0]     wdata_o;
    logic [DATA_W/8-1:0]   be_o;
    logic                  gnt_i;
    logic                  rvalid_i;
    logic                  err_i;

    modport master (
        output req_o, we_o, addr_o, wdata_o, be_o,
        input  gnt_i, rvalid_i, err_i
    );

    modport slave (
        input  req_o, we_o, addr_o, wdata_o, be_o,
        output gnt_i, rvalid_i, err_i
    );

endinterface

// File: rtl/boot_cfg_timer.sv
// Loadable down-counter; expired_o is high while the count is 1 or 0.
// Ports: s_clk, s_rst_n, load_i/load_val_i (load), dec_i (count down), expired_o.
module boot_cfg_timer #(
    parameter int W       = 8,
    parameter int RST_VAL = 1
) (
    input  logic         s_clk,
    input  logic         s_rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt;

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cnt <= W'(RST_VAL);
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (dec_i && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired_o = (cnt <= W'(1));

endmodule

// File: rtl/boot_cfg_sequencer.sv
// Boot sequencer: holds SoC reset, writes a config table over the bus, then
// enables fetch. Ports: s_clk, s_rst_n, restart_i, cfg_*_i table, soc_rst_n_o,
// bus (master), fetch_enable_o, done_o, error_o, err_idx_o.
module boot_cfg_sequencer
    import boot_cfg_pkg::*;
#(
    parameter int NUM_WRITES      = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int MAX_RETRIES     = 3,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                         s_clk,
    input  logic                         s_rst_n,
    input  logic                         restart_i,
    input  logic [NUM_WRITES*ADDR_W-1:0] cfg_addr_i,
    input  logic [NUM_WRITES*DATA_W-1:0] cfg_data_i,
    input  logic [NUM_WRITES-1:0]        cfg_en_i,
    output logic                         soc_rst_n_o,
    boot_cfg_sequencer_if.master         bus,
    output logic                         fetch_enable_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [3:0]                   err_idx_o
);

    localparam int IW   = cnt_w(NUM_WRITES);
    localparam int RW   = cnt_w(MAX_RETRIES);
    localparam int TMAX = (RST_HOLD_CYCLES > TIMEOUT_CYCLES) ?
                          RST_HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = cnt_w(TMAX);

    state_e            state;
    logic [IW-1:0]     idx;
    logic [RW-1:0]     retry;
    logic              restart_ok;
    logic              fail;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_exp;
    logic [TW-1:0]     tmr_val;
    logic [NUM_WRITES-1:0] en_sh;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign en_sh    = cfg_en_i >> idx;
    assign sel_addr = ADDR_W'(cfg_addr_i >> (ADDR_W * int'(idx)));
    assign sel_data = DATA_W'(cfg_data_i >> (DATA_W * int'(idx)));

    assign restart_ok = restart_i && (state == DONE || state == ERROR);

    // One timer serves the reset hold and the per-attempt timeout.
    // SELECT reloads it on every attempt, including retries.
    assign tmr_load = (state == SELECT) || restart_ok;
    assign tmr_val  = (state == SELECT) ? TW'(TIMEOUT_CYCLES)
                                        : TW'(RST_HOLD_CYCLES);
    assign tmr_dec  = (state == RST_HOLD) || (state == REQ) ||
                      (state == WAIT_RESP);

    // Timeout has priority over a grant in its last cycle so the
    // attempt budget is exact; a response in its last cycle still counts.
    assign fail = ((state == REQ) && tmr_exp) ||
                  ((state == WAIT_RESP) &&
                   (bus.rvalid_i ? bus.err_i : tmr_exp));

    assign bus.be_o = '1;

    boot_cfg_timer #(
        .W       (TW),
        .RST_VAL (RST_HOLD_CYCLES)
    ) u_timer (
        .s_clk      (s_clk),
        .s_rst_n    (s_rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .expired_o  (tmr_exp)
    );

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state          <= RST_HOLD;
            idx            <= '0;
            retry          <= '0;
            soc_rst_n_o    <= 1'b0;
            bus.req_o      <= 1'b0;
            bus.we_o       <= 1'b0;
            bus.addr_o     <= '0;
            bus.wdata_o    <= '0;
            fetch_enable_o <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            err_idx_o      <= '0;
        end else begin
            unique case (state)
                RST_HOLD: begin
                    if (tmr_exp) begin
                        soc_rst_n_o <= 1'b1;
                        idx         <= '0;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    if (idx == IW'(NUM_WRITES)) begin
                        done_o         <= 1'b1;
                        fetch_enable_o <= 1'b1;
                        state          <= DONE;
                    end else if (!en_sh[0]) begin
                        idx <= idx + 1'b1;
                    end else begin
                        bus.addr_o  <= sel_addr;
                        bus.wdata_o <= sel_data;
                        bus.req_o   <= 1'b1;
                        bus.we_o    <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ, WAIT_RESP: begin
                    if (fail) begin
                        bus.req_o <= 1'b0;
                        bus.we_o  <= 1'b0;
                        // Retry goes via SELECT: one idle cycle, timer reload.
                        if (retry < RW'(MAX_RETRIES)) begin
                            retry <= retry + 1'b1;
                            state <= SELECT;
                        end else begin
                            error_o   <= 1'b1;
                            err_idx_o <= 4'(idx);
                            state     <= ERROR;
                        end
                    end else if (state == REQ) begin
                        if (bus.gnt_i) begin
                            bus.req_o <= 1'b0;
                            bus.we_o  <= 1'b0;
                            state     <= WAIT_RESP;
                        end
                    end else if (bus.rvalid_i) begin
                        retry <= '0;
                        idx   <= idx + 1'b1;
                        state <= SELECT;
                    end
                end
                DONE, ERROR: begin
                    if (restart_i) begin
                        soc_rst_n_o    <= 1'b0;
                        fetch_enable_o <= 1'b0;
                        done_o         <= 1'b0;
                        error_o        <= 1'b0;
                        err_idx_o      <= '0;
                        idx            <= '0;
                        retry          <= '0;
                        state          <= RST_HOLD;
                    end
                end
                default: state <= RST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_cfg_sequencer.sv
// Directed bench for boot_cfg_sequencer: reset hold, skip mask, retry,
// timeout abort, restart and async reset, with a simple bus responder.
module tb_boot_cfg_sequencer;
    import boot_cfg_pkg::*;

    localparam int NW = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            rst_b_n;
    logic            restart;
    logic [NW*AW-1:0] cfg_addr;
    logic [NW*DW-1:0] cfg_data;
    logic [NW-1:0]   cfg_en;
    logic [NW-1:0]   cfg_en_b;
    logic            soc_rst_n, fetch, done, error;
    logic [3:0]      err_idx;
    logic            soc_b, fetch_b, done_b, error_b;
    logic [3:0]      err_idx_b;

    logic [31:0] A [4];
    logic [31:0] D [4];

    int nchk;
    int nerr;

    boot_cfg_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    boot_cfg_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    boot_cfg_sequencer #(
        .NUM_WRITES(NW), .ADDR_W(AW), .DATA_W(DW),
        .RST_HOLD_CYCLES(16), .MAX_RETRIES(3), .TIMEOUT_CYCLES(20)
    ) dut (
        .s_clk          (clk),
        .s_rst_n        (rst_n),
        .restart_i      (restart),
        .cfg_addr_i     (cfg_addr),
        .cfg_data_i     (cfg_data),
        .cfg_en_i       (cfg_en),
        .soc_rst_n_o    (soc_rst_n),
        .bus            (bus_a),
        .fetch_enable_o (fetch),
        .done_o         (done),
        .error_o        (error),
        .err_idx_o      (err_idx)
    );

    boot_cfg_sequencer #(
        .NUM_WRITES(NW), .ADDR_W(AW), .DATA_W(DW),
        .RST_HOLD_CYCLES(16), .MAX_RETRIES(1), .TIMEOUT_CYCLES(20)
    ) dut_b (
        .s_clk          (clk),
        .s_rst_n        (rst_b_n),
        .restart_i      (1'b0),
        .cfg_addr_i     (cfg_addr),
        .cfg_data_i     (cfg_data),
        .cfg_en_i       (cfg_en_b),
        .soc_rst_n_o    (soc_b),
        .bus            (bus_b),
        .fetch_enable_o (fetch_b),
        .done_o         (done_b),
        .error_o        (error_b),
        .err_idx_o      (err_idx_b)
    );

    // Responder for dut: grant after gdly cycles of req, respond next cycle.
    int          gdly = 2;
    bit          gnt_en;
    logic [31:0] err_addr;
    int          err_left;
    bit          pend;
    int          gcnt;
    logic [31:0] last_addr;
    logic [31:0] wa [$];
    logic [31:0] wd [$];
    logic [4:0]  wb [$];

    always @(negedge clk) begin
        bus_a.gnt_i    = 1'b0;
        bus_a.rvalid_i = 1'b0;
        bus_a.err_i    = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
            gcnt = 0;
        end else if (pend) begin
            pend = 1'b0;
            bus_a.rvalid_i = 1'b1;
            if (err_left > 0 && last_addr == err_addr) begin
                bus_a.err_i = 1'b1;
                err_left--;
            end
        end else if (bus_a.req_o && gnt_en) begin
            if (gcnt >= gdly) begin
                bus_a.gnt_i = 1'b1;
                gcnt = 0;
                pend = 1'b1;
                last_addr = bus_a.addr_o;
                wa.push_back(bus_a.addr_o);
                wd.push_back(bus_a.wdata_o);
                wb.push_back({bus_a.we_o, bus_a.be_o});
            end else begin
                gcnt++;
            end
        end else begin
            gcnt = 0;
        end
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        wa.delete();
        wd.delete();
        wb.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        clr_log();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done || error) break;
        end
        check("end_reached", done | error, 1);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_a.req_o) break;
        end
        check("req_seen", bus_a.req_o, 1);
    endtask

    initial begin
        int n;
        int cnt2;
        int att;
        int len;
        logic prv;
        int lens [$];

        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        rst_b_n = 1'b0;
        restart = 1'b0;
        gnt_en = 1'b1;
        err_addr = '0;
        err_left = 0;
        A[0] = BOOT_ADDR_REG; D[0] = 32'h0;
        A[1] = 32'h1A10_0010; D[1] = 32'h0000_0011;
        A[2] = 32'h1A10_0020; D[2] = 32'h0000_0022;
        A[3] = 32'h1A10_0030; D[3] = 32'h0000_0033;
        for (int k = 0; k < NW; k++) begin
            cfg_addr[k*AW +: AW] = A[k];
            cfg_data[k*DW +: DW] = D[k];
        end
        cfg_en = 4'b0001;
        cfg_en_b = 4'b1110;
        bus_b.gnt_i = 1'b0;
        bus_b.rvalid_i = 1'b0;
        bus_b.err_i = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_soc", soc_rst_n, 0);
        check("rst_req", bus_a.req_o, 0);
        check("rst_we", bus_a.we_o, 0);
        check("rst_addr", bus_a.addr_o, 0);
        check("rst_wdata", bus_a.wdata_o, 0);
        check("rst_be", bus_a.be_o, 4'hF);
        check("rst_fetch", fetch, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_idx", err_idx, 0);

        // Single entry: reset hold length, then one write.
        #1 rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (soc_rst_n) begin
                n = i;
                break;
            end
        end
        check("hold_cycles", n, 16);
        wait_end();
        check("t1_nw", wa.size(), 1);
        if (wa.size() >= 1) begin
            check("t1_addr", wa[0], BOOT_ADDR_REG);
            check("t1_data", wd[0], 0);
            check("t1_we_be", wb[0], 5'h1F);
        end
        check("t1_done", done, 1);
        check("t1_fetch", fetch, 1);
        check("t1_error", error, 0);
        check("t1_soc", soc_rst_n, 1);

        // Skip mask: only entries 1 and 3.
        cfg_en = 4'b1010;
        pulse_reset();
        wait_end();
        check("t2_nw", wa.size(), 2);
        if (wa.size() >= 2) begin
            check("t2_addr0", wa[0], A[1]);
            check("t2_addr1", wa[1], A[3]);
            check("t2_data1", wd[1], D[3]);
        end
        check("t2_done", done, 1);

        // Entry 2 errors twice, then succeeds.
        cfg_en = 4'b1111;
        err_addr = A[2];
        err_left = 2;
        pulse_reset();
        wait_end();
        check("t3_nw", wa.size(), 6);
        cnt2 = 0;
        foreach (wa[i]) if (wa[i] == A[2]) cnt2++;
        check("t3_entry2_reqs", cnt2, 3);
        if (wa.size() == 6) check("t3_last", wa[5], A[3]);
        check("t3_done", done, 1);
        check("t3_error", error, 0);

        // No grants: all four attempts on entry 0 time out.
        gnt_en = 1'b0;
        pulse_reset();
        wait_end();
        check("t4_error", error, 1);
        check("t4_err_idx", err_idx, 0);
        check("t4_fetch", fetch, 0);
        check("t4_done", done, 0);
        check("t4_soc", soc_rst_n, 1);
        check("t4_nw", wa.size(), 0);

        // Restart from ERROR with a clean bus.
        gnt_en = 1'b1;
        clr_log();
        #1 restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rs_error_clr", error, 0);
        check("rs_soc_low", soc_rst_n, 0);
        check("rs_fetch", fetch, 0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (soc_rst_n) break;
            n++;
        end
        check("rs_hold_cycles", n, 16);

        // Restart while in REQ is ignored.
        wait_req();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rs_ignored_soc", soc_rst_n, 1);
        wait_end();
        check("rs_nw", wa.size(), 4);
        if (wa.size() == 4) begin
            for (int k = 0; k < 4; k++) check("rs_order", wa[k], A[k]);
        end
        check("rs_done", done, 1);
        check("rs_fetch_on", fetch, 1);

        // Async reset while req_o is high.
        #1 restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_req();
        #2 rst_n = 1'b0;
        #1;
        check("ar_req", bus_a.req_o, 0);
        check("ar_soc", soc_rst_n, 0);
        clr_log();
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_end();
        check("ar_nw", wa.size(), 4);
        if (wa.size() >= 1) check("ar_first", wa[0], A[0]);
        check("ar_done", done, 1);

        // Second instance: entry 1 never granted, one retry, 20-cycle timeout.
        @(negedge clk);
        #1 rst_b_n = 1'b1;
        att = 0;
        len = 0;
        prv = 1'b0;
        for (int i = 0; i < 400 && !error_b; i++) begin
            @(negedge clk);
            if (bus_b.req_o) begin
                len++;
            end else if (prv) begin
                lens.push_back(len);
                len = 0;
            end
            if (bus_b.req_o && !prv) att++;
            prv = bus_b.req_o;
        end
        check("to_attempts", att, 2);
        check("to_nlens", lens.size(), 2);
        if (lens.size() == 2) begin
            check("to_len0", lens[0], 20);
            check("to_len1", lens[1], 20);
        end
        check("to_error", error_b, 1);
        check("to_err_idx", err_idx_b, 1);
        check("to_fetch", fetch_b, 0);
        check("to_done", done_b, 0);
        check("to_soc", soc_b, 1);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
